// File: rtl/hls_call_issuer_if.sv
// hls_call_issuer_if: bundles the operand, callee and result handshakes of
// the call issuer. The slave modport is the issuer's view; the master modport
// is the view of the environment that feeds operands, hosts the callee and
// consumes results.
`timescale 1ns/1ps

interface hls_call_issuer_if #(
   parameter int WIDTH = 32
);
   // operand side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   // callee side
   logic             call_req;
   logic             call_ack;
   logic [WIDTH-1:0] call_p0;
   logic [WIDTH-1:0] call_p1;
   logic [WIDTH-1:0] call_out;
   // result side
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   // status
   logic [7:0]       err_count;
   logic             busy;

   modport slave (
      input  in_valid, in_a, in_b, call_ack, call_out, res_ready,
      output in_ready, call_req, call_p0, call_p1,
             res_valid, res_data, res_err, err_count, busy
   );

   modport master (
      output in_valid, in_a, in_b, call_ack, call_out, res_ready,
      input  in_ready, call_req, call_p0, call_p1,
             res_valid, res_data, res_err, err_count, busy
   );
endinterface

// File: rtl/hls_call_issuer.sv
// hls_call_issuer: issues one call at a time to a callee unit with a
// req/ack handshake, bounds the wait with a timeout, waits for a held ack
// to drop before presenting the result, and holds the result until the
// consumer takes it. A timed-out call yields res_data=0 with res_err=1 and
// bumps a saturating error counter.
`timescale 1ns/1ps

module hls_call_issuer #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   hls_call_issuer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALL   = 2'd1,
      S_DRAIN  = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   // Last counter value before the wait is declared a timeout.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_t           r_state;
   logic             r_call_req;
   logic             r_res_valid;
   logic             r_busy;
   logic [WIDTH-1:0] r_call_p0;
   logic [WIDTH-1:0] r_call_p1;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_err;
   logic [7:0]       r_err_count;
   logic [15:0]      r_wait_cnt;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_timeout;
   logic [7:0]       w_err_next;

   // A stale ack still high from the previous call blocks a new accept,
   // so in_ready must see call_ack combinationally.
   assign w_in_ready = (r_state == S_IDLE) && !bus.call_ack;
   assign w_accept   = w_in_ready && bus.in_valid;
   // An ack in the same cycle as the last wait cycle wins over the timeout.
   assign w_timeout  = !bus.call_ack && (r_wait_cnt == TIMEOUT_LAST);
   assign w_err_next = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);

   assign bus.in_ready  = w_in_ready;
   assign bus.call_req  = r_call_req;
   assign bus.call_p0   = r_call_p0;
   assign bus.call_p1   = r_call_p1;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_err   = r_res_err;
   assign bus.err_count = r_err_count;
   assign bus.busy      = r_busy;

   // Call sequencing FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_call_req  <= 1'b0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_call_p0   <= '0;
         r_call_p1   <= '0;
         r_res_data  <= '0;
         r_res_err   <= 1'b0;
         r_err_count <= 8'd0;
         r_wait_cnt  <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_call_p0  <= bus.in_a;
                  r_call_p1  <= bus.in_b;
                  r_wait_cnt <= 16'd0;
                  r_call_req <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_CALL;
               end else begin
                  r_state    <= S_IDLE;
               end
            end
            S_CALL: begin
               if (bus.call_ack) begin
                  r_res_data <= bus.call_out;
                  r_res_err  <= 1'b0;
                  r_call_req <= 1'b0;
                  r_state    <= S_DRAIN;
               end else if (w_timeout) begin
                  r_res_data  <= '0;
                  r_res_err   <= 1'b1;
                  r_err_count <= w_err_next;
                  r_wait_cnt  <= r_wait_cnt + 16'd1;
                  r_call_req  <= 1'b0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_DRAIN: begin
               // Present the result only once the callee has released ack.
               if (!bus.call_ack) begin
                  r_res_valid <= 1'b1;
                  r_state     <= S_RESULT;
               end else begin
                  r_state     <= S_DRAIN;
               end
            end
            S_RESULT: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state     <= S_RESULT;
               end
            end
            default: begin
               r_call_req  <= 1'b0;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hls_call_issuer.sv
// tb_hls_call_issuer: directed and randomized transactions against a
// transaction-level expectation of when each phase of a call occurs, plus a
// second instance with a short timeout for timeout, tie and saturation cases.
`timescale 1ns/1ps

module tb_hls_call_issuer;

   localparam int W  = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;
   int m_err    = 0;   // expected err_count of the main instance

   hls_call_issuer_if #(.WIDTH(W)) bus  ();
   hls_call_issuer_if #(.WIDTH(W)) bus4 ();

   hls_call_issuer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   hls_call_issuer #(.WIDTH(W), .TIMEOUT(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit ack_at(input int c, input int lat, input int hold);
      return (c >= lat) && (c < lat + hold);
   endfunction

   // One whole call on the main instance. Starts at a negedge in IDLE with
   // call_ack low; ends at a negedge in IDLE with call_ack low.
   // Cycle 0 is the first cycle after the accepting edge. The callee raises
   // ack at cycle lat for hold cycles; the consumer refuses bp result cycles.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] val, input int lat,
                          input int hold, input int bp);
      bit timed_out;
      int t_end, c_low, r_first, r_last, c_end, e_old, e_new;
      bit ack_c, rv;
      logic [W-1:0] exp_data;

      timed_out = (lat >= TO);
      t_end     = timed_out ? TO - 1 : lat;        // last cycle with call_req
      c_low     = t_end + 1;
      while (ack_at(c_low, lat, hold)) c_low++;    // first ack-low cycle after
      r_first   = c_low + 1;
      r_last    = r_first + bp;
      c_end     = (r_last + 1 > lat + hold) ? r_last + 1 : lat + hold;
      exp_data  = timed_out ? '0 : val;
      e_old     = m_err;
      e_new     = (timed_out && m_err < 255) ? m_err + 1 : m_err;

      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.call_ack  = 1'b0;
      bus.res_ready = 1'b0;
      #1;
      chk("accept_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom();
      bus.in_b     = $urandom();

      for (int c = 0; c <= c_end; c++) begin
         ack_c         = ack_at(c, lat, hold);
         bus.call_ack  = ack_c;
         bus.call_out  = ack_c ? val : W'($urandom());
         bus.res_ready = (c >= r_last);
         #1;
         rv = (c >= r_first) && (c <= r_last);
         chk("call_req",  bus.call_req,  c <= t_end);
         chk("res_valid", bus.res_valid, rv);
         chk("busy",      bus.busy,      c <= r_last);
         chk("in_ready",  bus.in_ready,  (c > r_last) && !ack_c);
         chk("call_p0",   bus.call_p0,   a);
         chk("call_p1",   bus.call_p1,   b);
         chk("err_count", bus.err_count, (c > t_end) ? e_new : e_old);
         if (rv) begin
            chk("res_data", bus.res_data, exp_data);
            chk("res_err",  bus.res_err,  timed_out);
         end
         if (c < c_end) @(negedge clk);
      end
      bus.call_ack = 1'b0;
      m_err = e_new;
   endtask

   initial begin
      int n, n_req, n_res;

      reset          = 1'b1;
      bus.in_valid   = 1'b0;  bus.in_a  = '0;  bus.in_b  = '0;
      bus.call_ack   = 1'b0;  bus.call_out = '0; bus.res_ready = 1'b0;
      bus4.in_valid  = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;
      bus4.call_ack  = 1'b0;  bus4.call_out = '0; bus4.res_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_call_req",  bus.call_req,  1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_busy",      bus.busy,      1'b0);
      chk("rst_res_err",   bus.res_err,   1'b0);
      chk("rst_err_count", bus.err_count, 8'd0);
      chk("rst_call_p0",   bus.call_p0,   32'd0);
      chk("rst_res_data",  bus.res_data,  32'd0);
      chk("rst_in_ready",  bus.in_ready,  1'b1);

      // Nominal: ack 8 cycles after req, single-cycle pulse.
      run_txn(32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 8, 1, 0);
      // Ack on the very first request cycle.
      run_txn(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 1, 0);
      // Held ack for 5 cycles.
      run_txn(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 2, 5, 0);
      // Backpressure for 10 cycles.
      run_txn(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 3, 1, 10);
      // Ack on the timeout cycle wins.
      run_txn(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, TO - 1, 1, 1);
      // Timeout, ack arriving on the first drain cycle and held.
      run_txn(32'h4444_4444, 32'h5555_5555, 32'h6666_6666, TO, 3, 0);
      // Timeout, late ack landing in the result/idle phase.
      run_txn(32'h7777_7777, 32'h8888_8888, 32'h9999_9999, TO + 2, 4, 0);

      for (int i = 0; i < 40; i++) begin
         run_txn($urandom(), $urandom(), $urandom(),
                 $urandom_range(0, TO + 2), $urandom_range(1, 4),
                 $urandom_range(0, 3));
      end

      // Short-timeout instance: never acked.
      @(negedge clk);
      bus4.in_valid  = 1'b1;
      bus4.in_a      = 32'hAAAA_0001;
      bus4.in_b      = 32'hBBBB_0002;
      bus4.res_ready = 1'b1;
      #1;
      chk("t4_in_ready", bus4.in_ready, 1'b1);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      n_req = 0;
      n = 0;
      while (!bus4.res_valid && n < 30) begin
         if (bus4.call_req) n_req++;
         n++;
         @(negedge clk);
      end
      chk("t4_req_cycles", n_req, 4);
      chk("t4_res_valid",  bus4.res_valid, 1'b1);
      chk("t4_res_data",   bus4.res_data,  32'd0);
      chk("t4_res_err",    bus4.res_err,   1'b1);
      chk("t4_err_count",  bus4.err_count, 8'd1);
      @(negedge clk);
      chk("t4_idle_busy",  bus4.busy, 1'b0);

      // Short-timeout instance: ack exactly on the timeout cycle.
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      bus4.call_ack = 1'b1;
      bus4.call_out = 32'h1357_9BDF;
      @(negedge clk);
      bus4.call_ack = 1'b0;
      bus4.call_out = 32'hFFFF_FFFF;
      n = 0;
      while (!bus4.res_valid && n < 30) begin
         n++;
         @(negedge clk);
      end
      chk("tie_res_valid", bus4.res_valid, 1'b1);
      chk("tie_res_err",   bus4.res_err,   1'b0);
      chk("tie_res_data",  bus4.res_data,  32'h1357_9BDF);
      chk("tie_err_count", bus4.err_count, 8'd1);
      @(negedge clk);

      // Short-timeout instance: 259 more timeouts back to back.
      bus4.in_valid = 1'b1;
      n_res = 0;
      n = 0;
      while (n_res < 259 && n < 4000) begin
         @(negedge clk);
         n++;
         if (bus4.res_valid) begin
            n_res++;
            if (n_res == 259) bus4.in_valid = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      chk("sat_results",   n_res, 259);
      chk("sat_err_count", bus4.err_count, 8'd255);
      chk("sat_busy",      bus4.busy, 1'b0);

      // Reset three cycles into CALL.
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h0BAD_F00D;
      bus.in_b     = 32'h0BAD_CAFE;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rc_pre_call_req", bus.call_req, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rc_call_req",   bus.call_req,  1'b0);
      chk("rc_busy",       bus.busy,      1'b0);
      chk("rc_res_valid",  bus.res_valid, 1'b0);
      chk("rc_err_count",  bus.err_count, 8'd0);
      chk("rc_in_ready",   bus.in_ready,  1'b1);
      chk("rc_call_p0",    bus.call_p0,   32'd0);
      chk("rc_t4_errcnt",  bus4.err_count, 8'd0);
      m_err = 0;

      // Reset while a result is held.
      bus.in_valid  = 1'b1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.call_ack = 1'b1;
      bus.call_out = 32'h2468_ACE0;
      @(negedge clk);
      bus.call_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("rr_pre_valid", bus.res_valid, 1'b1);
      chk("rr_pre_data",  bus.res_data,  32'h2468_ACE0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rr_res_valid", bus.res_valid, 1'b0);
      chk("rr_res_data",  bus.res_data,  32'd0);
      chk("rr_busy",      bus.busy,      1'b0);
      chk("rr_in_ready",  bus.in_ready,  1'b1);

      // Normal operation after reset.
      run_txn(32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 8, 1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hls_call_issuer.md
HLS_CALL_ISSUER -- requirements
Module: hls_call_issuer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the operand and result data paths.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles to wait for call_ack, legal range 2..65535.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL signal that an operand pair is offered.
REQ-006 in_ready  output  1  SHALL signal that the issuer accepts an operand pair this cycle.
REQ-007 in_a, in_b  input  WIDTH each  SHALL carry the operand pair.
REQ-008 call_req  output  1  SHALL be the request to the callee unit.
REQ-009 call_ack  input  1  SHALL be the acknowledgement from the callee unit.
REQ-010 call_p0, call_p1  output  WIDTH each  SHALL drive the callee operands.
REQ-011 call_out  input  WIDTH  SHALL carry the callee result.
REQ-012 res_valid  output  1  SHALL signal that a result is held.
REQ-013 res_ready  input  1  SHALL signal that the consumer takes the result.
REQ-014 res_data  output  WIDTH  SHALL carry the result value.
REQ-015 res_err  output  1  SHALL flag a timed-out call alongside res_data.
REQ-016 err_count  output  8  SHALL count timeouts since reset, saturating at 255.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, CALL, DRAIN and RESULT.
REQ-019 in_ready SHALL equal (state==IDLE) && !call_ack, so that no new call starts while a stale ack is still high.
REQ-020 In IDLE, when in_valid && in_ready, the issuer SHALL register in_a into call_p0 and in_b into call_p1, clear the wait counter, and enter CALL.
REQ-021 call_req SHALL be registered and SHALL be high exactly while state==CALL.
REQ-022 call_p0 and call_p1 SHALL stay stable from CALL entry until the next accepted operand pair.
REQ-023 In CALL, the wait counter (16-bit) SHALL increment every cycle that call_ack is low.
REQ-024 In CALL with call_ack=1, the issuer SHALL capture call_out into res_data, clear res_err, and enter DRAIN.
REQ-025 In CALL with call_ack=0 and counter==TIMEOUT-1, the issuer SHALL:
  - set res_data to 0 and res_err to 1;
  - increment err_count, saturating at 255;
  - enter DRAIN.
REQ-026 If call_ack rises in the same cycle that the timeout is reached, the ack SHALL win.
REQ-027 In DRAIN, the issuer SHALL move to RESULT on the first cycle with call_ack=0 and stay in DRAIN otherwise.
REQ-028 res_valid SHALL be high exactly while state==RESULT.
REQ-029 res_data and res_err SHALL stay stable while res_valid is high.
REQ-030 In RESULT with res_ready=1, the issuer SHALL return to IDLE.
REQ-031 Back-to-back accept SHALL require one IDLE cycle, so there is no same-cycle RESULT-to-CALL bypass.
REQ-032 call_ack SHALL be ignored in IDLE and RESULT, except for its effect on in_ready.
REQ-033 Latency timing, for acceptance at cycle T and a callee acking at the first cycle of request plus L:
  - call_req high from T+1;
  - ack at T+1+L;
  - res_valid from T+3+L when the ack is a single-cycle pulse.
REQ-034 Only one call SHALL be outstanding at any time.

Reset
REQ-035 When reset is high at a clock edge, the issuer SHALL go to IDLE regardless of state, including mid-CALL and mid-RESULT.
REQ-036 Reset SHALL clear call_req, res_valid, res_err, busy, err_count, the wait counter, call_p0, call_p1 and res_data to 0.
REQ-037 in_ready SHALL be high on the first cycle after reset provided call_ack is low.
REQ-038 A result held in RESULT when reset is asserted SHALL be discarded.

Verification
REQ-039 Nominal: in_a=0x40400000, in_b=0x40000000, callee acks 8 cycles after req with call_out=0x3FC00000 -> call_req high for 9 cycles, res_data=0x3FC00000, res_err=0, res_valid rises 2 cycles after the ack.
REQ-040 Timeout: TIMEOUT=4, callee never acks -> call_req high exactly 4 cycles, res_valid with res_data=0 and res_err=1, err_count=1.
REQ-041 Held ack: callee holds call_ack high for 5 cycles -> issuer stays in DRAIN until ack falls, in_ready stays low throughout, only one result produced.
REQ-042 Backpressure: res_ready held low 10 cycles -> res_valid and res_data stable all 10 cycles, in_ready=0, no second call_req.
REQ-043 Reset mid-CALL: reset asserted 3 cycles into CALL -> next cycle call_req=0, busy=0, res_valid=0, err_count=0, in_ready=1.
REQ-044 Saturation and tie: 260 consecutive timeouts -> err_count=255; ack arriving on the timeout cycle -> res_err=0 and err_count unchanged.
